// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds bytes from two requesters into one shared UART
// transmitter. Each transfer is a write strobe followed by a busy handshake, with a timeout.
module uart_tx_arbiter #(
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       cfg_wr,
  input  logic [2:0] cfg_baud,
  input  logic       a_valid,
  input  logic       b_valid,
  input  logic [7:0] a_data,
  input  logic [7:0] b_data,
  output logic       a_ready,
  output logic       b_ready,
  input  logic       Tx_BUSY,
  output logic [7:0] Tx_DATA,
  output logic       Tx_WR,
  output logic       TX_EN,
  output logic [2:0] baud_select,
  output logic       grant_id,
  output logic       ctrl_busy,
  output logic       timeout_err,
  output logic       cfg_rej
);

  typedef enum logic [1:0] {IDLE, WRITE, WAIT_ACK, WAIT_DONE} state_t;

  // The counter only has to reach BUSY_TIMEOUT-1, which is the last cycle before the timeout fires.
  localparam int CW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          ptr_b;  // 1: B wins when both requesters are valid
  logic          pick_b;

  assign pick_b = b_valid && (!a_valid || ptr_b);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      ptr_b       <= 1'b0;
      Tx_DATA     <= 8'h00;
      Tx_WR       <= 1'b0;
      TX_EN       <= 1'b0;
      baud_select <= 3'b000;
      grant_id    <= 1'b0;
      a_ready     <= 1'b0;
      b_ready     <= 1'b0;
      ctrl_busy   <= 1'b0;
      timeout_err <= 1'b0;
      cfg_rej     <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here make every pulse output last exactly one cycle,
      // unless a case branch further down sets that output again in the same cycle.
      a_ready     <= 1'b0;
      b_ready     <= 1'b0;
      Tx_WR       <= 1'b0;
      timeout_err <= 1'b0;
      cfg_rej     <= 1'b0;
      TX_EN       <= en;

      if (cfg_wr) begin
        if (state == IDLE) baud_select <= cfg_baud;
        else               cfg_rej     <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (en && (a_valid || b_valid)) begin
            state     <= WRITE;
            ctrl_busy <= 1'b1;
            grant_id  <= pick_b;
            ptr_b     <= !pick_b;
            Tx_DATA   <= pick_b ? b_data : a_data;
            a_ready   <= !pick_b;
            b_ready   <= pick_b;
          end
        end
        WRITE: begin
          Tx_WR <= 1'b1;
          cnt   <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (Tx_BUSY) begin
            state <= WAIT_DONE;
          end else if (cnt == CNT_LAST) begin
            timeout_err <= 1'b1;
            ctrl_busy   <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_DONE: begin
          if (!Tx_BUSY) begin
            ctrl_busy <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          ctrl_busy <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter. A transfer-timeline reference model
// predicts every registered output after each clock edge.
module tb_uart_tx_arbiter;

  localparam int TO = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [2:0] cfg_baud = 3'b000;
  logic       a_valid = 1'b0;
  logic       b_valid = 1'b0;
  logic [7:0] a_data = 8'h00;
  logic [7:0] b_data = 8'h00;
  logic       Tx_BUSY = 1'b0;
  logic       a_ready, b_ready, Tx_WR, TX_EN, grant_id, ctrl_busy, timeout_err, cfg_rej;
  logic [7:0] Tx_DATA;
  logic [2:0] baud_select;

  uart_tx_arbiter #(.BUSY_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .en(en), .cfg_wr(cfg_wr), .cfg_baud(cfg_baud),
    .a_valid(a_valid), .b_valid(b_valid), .a_data(a_data), .b_data(b_data),
    .a_ready(a_ready), .b_ready(b_ready), .Tx_BUSY(Tx_BUSY), .Tx_DATA(Tx_DATA),
    .Tx_WR(Tx_WR), .TX_EN(TX_EN), .baud_select(baud_select), .grant_id(grant_id),
    .ctrl_busy(ctrl_busy), .timeout_err(timeout_err), .cfg_rej(cfg_rej)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a transfer is a timeline measured from its grant, not a state machine.
  bit       m_active, m_acked, m_ptr_b, m_gid, m_txen;
  int       m_age;
  bit [7:0] m_data;
  bit [2:0] m_baud;
  bit       e_ra, e_rb, e_wr, e_to, e_rej;

  function automatic void model_reset();
    m_active = 0; m_acked = 0; m_ptr_b = 0; m_gid = 0; m_txen = 0;
    m_age = 0; m_data = 8'h00; m_baud = 3'b000;
    e_ra = 0; e_rb = 0; e_wr = 0; e_to = 0; e_rej = 0;
  endfunction

  function automatic void model_step();
    bit win_b;
    e_ra = 0; e_rb = 0; e_wr = 0; e_to = 0; e_rej = 0;
    if (cfg_wr) begin
      if (!m_active) m_baud = cfg_baud;
      else           e_rej = 1;
    end
    m_txen = en;
    if (!m_active) begin
      if (en && (a_valid || b_valid)) begin
        win_b    = b_valid && (!a_valid || m_ptr_b);
        m_ptr_b  = !win_b;
        m_gid    = win_b;
        m_data   = win_b ? b_data : a_data;
        e_ra     = !win_b;
        e_rb     = win_b;
        m_active = 1; m_age = 0; m_acked = 0;
      end
    end else if (m_age == 0) begin
      e_wr  = 1;                  // the strobe goes out one cycle after the grant
      m_age = 1;
    end else if (!m_acked) begin
      if (Tx_BUSY)          m_acked = 1;
      else if (m_age == TO) begin e_to = 1; m_active = 0; end
      else                  m_age++;
    end else if (!Tx_BUSY) begin
      m_active = 0;
    end
  endfunction

  logic [18:0] dut_o;
  assign dut_o = {a_ready, b_ready, Tx_WR, TX_EN, grant_id, ctrl_busy, timeout_err, cfg_rej,
                  baud_select, Tx_DATA};

  function automatic logic [18:0] model_o();
    return {e_ra, e_rb, e_wr, m_txen, m_gid, m_active, e_to, e_rej, m_baud, m_data};
  endfunction

  // Transmitter stand-in: Tx_BUSY rises bdly cycles after a strobe and stays high for blen cycles.
  bit auto_busy = 0, rand_busy = 0;
  int bdly = 0, blen = 0, since = 1000;

  task automatic drive_busy();
    if (!auto_busy) return;
    if (Tx_WR) begin
      since = 0;
      if (rand_busy) begin
        bdly = $urandom_range(0, TO + 2);
        blen = $urandom_range(0, 6);
      end
    end else if (since < 1000) begin
      since++;
    end
    Tx_BUSY = (since >= bdly) && (since < bdly + blen);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    if (reset) model_step();
    else       model_reset();
    #1;
    check(tag, 32'(dut_o), 32'(model_o()));
    drive_busy();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    Tx_BUSY = 1'b0; since = 1000;
    a_valid = 0; b_valid = 0; cfg_wr = 0;
    cycle("reset");
    cycle("reset");
    reset = 1'b1;
  endtask

  task automatic drain(input int n);
    a_valid = 0; b_valid = 0;
    for (int i = 0; i < n; i++) cycle("drain");
  endtask

  // Issue one A request and stop on the cycle after its strobe, when the arbiter is waiting
  // for busy to fall.
  task automatic reach_wait_done(input string tag);
    bit seen = 0;
    a_valid = 1; a_data = 8'($urandom);
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(tag);
      if (a_ready) a_valid = 0;
      if (Tx_WR) seen = 1;
    end
    check({tag, "_wr_seen"}, 32'(seen), 32'd1);
    cycle(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ra, n_wr, wr_cyc, to_cyc, n_g;
    logic [8:0] gq [4];
    model_reset();

    #1;
    check("rst_init", 32'(dut_o), 32'd0);
    do_reset();

    // A single requester while the transmitter acknowledges promptly.
    en = 1; auto_busy = 1; bdly = 2; blen = 10;
    a_valid = 1; a_data = 8'h55; n_ra = 0; n_wr = 0;
    for (int i = 0; i < 24; i++) begin
      cycle("single");
      if (a_ready) begin n_ra++; a_valid = 0; end
      if (Tx_WR) n_wr++;
    end
    check("single_ready_cnt", 32'(n_ra), 32'd1);
    check("single_wr_cnt", 32'(n_wr), 32'd1);
    check("single_data", 32'(Tx_DATA), 32'h55);
    check("single_idle", 32'(ctrl_busy), 32'd0);

    // Both requesters held valid: the grants must alternate, starting with A.
    do_reset();
    en = 1; bdly = 0; blen = 2;
    a_data = 8'hA1; b_data = 8'hB2; a_valid = 1; b_valid = 1;
    n_g = 0;
    for (int i = 0; i < 4; i++) gq[i] = 'x;
    for (int i = 0; i < 80 && n_g < 4; i++) begin
      cycle("contend");
      if (a_ready || b_ready) begin gq[n_g] = {b_ready, Tx_DATA}; n_g++; end
    end
    for (int i = 0; i < 4; i++)
      check("contend_order", 32'(gq[i]), (i % 2) ? 32'h1B2 : 32'h0A1);
    drain(20);

    // The transmitter never goes busy, so the request must time out.
    bdly = 0; blen = 0; a_valid = 1; a_data = 8'h3C;
    wr_cyc = -1; to_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      cycle("timeout");
      if (a_ready) a_valid = 0;
      if (Tx_WR && wr_cyc < 0) wr_cyc = i;
      if (timeout_err && to_cyc < 0) to_cyc = i;
    end
    check("timeout_lat", 32'(to_cyc - wr_cyc), 32'(TO));
    check("timeout_idle", 32'(ctrl_busy), 32'd0);

    // A config write is accepted in IDLE and rejected while waiting for busy to fall.
    cfg_wr = 1; cfg_baud = 3'b111;
    cycle("cfg_idle");
    cfg_wr = 0;
    check("cfg_baud_idle", 32'(baud_select), 32'h7);
    bdly = 0; blen = 8;
    reach_wait_done("cfg");
    cfg_wr = 1; cfg_baud = 3'b010;
    cycle("cfg_busy");
    cfg_wr = 0;
    check("cfg_rej", 32'(cfg_rej), 32'd1);
    check("cfg_baud_kept", 32'(baud_select), 32'h7);
    drain(20);

    // Asynchronous reset while waiting for busy to fall.
    bdly = 0; blen = 20;
    reach_wait_done("rstwd");
    #2 reset = 1'b0;
    #1 check("rst_async", 32'(dut_o), 32'd0);
    cycle("rst_hold");
    cycle("rst_hold");
    reset = 1'b1;
    n_wr = 0;
    for (int i = 0; i < 10; i++) begin
      cycle("rst_after");
      if (Tx_WR || a_ready || b_ready) n_wr++;
    end
    check("rst_no_wr", 32'(n_wr), 32'd0);
    drain(25);

    // No grant while en is low; the grant follows one edge after en returns.
    en = 0; a_valid = 1; a_data = 8'h77; bdly = 0; blen = 2; n_ra = 0;
    for (int i = 0; i < 5; i++) begin
      cycle("en_low");
      if (a_ready || Tx_WR) n_ra++;
    end
    check("en_low_none", 32'(n_ra), 32'd0);
    en = 1;
    cycle("en_high");
    check("en_grant", 32'(a_ready), 32'd1);
    drain(10);

    // Random traffic, including a busy transmitter, occasional resets and config writes.
    rand_busy = 1;
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      a_valid  = ($urandom_range(0, 2) != 0);
      b_valid  = ($urandom_range(0, 2) != 0);
      a_data   = 8'($urandom);
      b_data   = 8'($urandom);
      cfg_wr   = ($urandom_range(0, 7) == 0);
      cfg_baud = 3'($urandom);
      reset    = ($urandom_range(0, 499) != 0);
      cycle("random");
      reset = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter BUSY_TIMEOUT, default 15: cycles to wait in WAIT_ACK for Tx_BUSY to rise.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset (reset=0 asserts).
REQ-004 Port en  input  1  enable; grants are made only while en=1.
REQ-005 Port cfg_wr  input  1  one-cycle request to load a new baud select.
REQ-006 Port cfg_baud  input  3  baud select value written by cfg_wr.
REQ-007 Port a_valid / b_valid  input  1 each  requester A/B holds a byte for transmission.
REQ-008 Port a_data / b_data  input  8 each  byte from requester A/B, stable while its valid=1.
REQ-009 Port a_ready / b_ready  output  1 each  one-cycle accept pulse to requester A/B.
REQ-010 Port Tx_BUSY  input  1  busy flag from the shared UART transmitter.
REQ-011 Port Tx_DATA  output  8  byte presented to the transmitter.
REQ-012 Port Tx_WR  output  1  one-cycle write strobe to the transmitter.
REQ-013 Port TX_EN  output  1  transmitter enable, equal to registered en.
REQ-014 Port baud_select  output  3  registered baud configuration.
REQ-015 Port grant_id  output  1  last granted requester (0=A, 1=B).
REQ-016 Port ctrl_busy  output  1  high whenever state is not IDLE.
REQ-017 Port timeout_err  output  1  one-cycle pulse on WAIT_ACK timeout.
REQ-018 Port cfg_rej  output  1  one-cycle pulse when cfg_wr arrives outside IDLE.

Function
REQ-019 FSM states: IDLE, WRITE, WAIT_ACK, WAIT_DONE; all outputs registered.
REQ-020 IDLE, en=1, any valid: grant per round-robin pointer; latch data into Tx_DATA; pulse that requester's ready; set grant_id; go WRITE.
REQ-021 Round-robin: pointer starts at A; if only one valid, that one wins; if both valid, pointer side wins; pointer flips to the non-granted side on every grant.
REQ-022 WRITE: Tx_WR=1 for exactly this one cycle; go WAIT_ACK; cycle counter cleared.
REQ-023 WAIT_ACK: Tx_BUSY=1 -> WAIT_DONE; else counter increments; counter reaching BUSY_TIMEOUT -> pulse timeout_err, go IDLE, byte dropped.
REQ-024 WAIT_DONE: Tx_BUSY=0 -> IDLE; no upper time bound.
REQ-025 Latency: valid seen in IDLE -> ready pulse next edge -> Tx_WR high the following cycle (ready and Tx_WR never overlap).
REQ-026 Min spacing between consecutive Tx_WR pulses is 4 cycles (WRITE, WAIT_ACK, WAIT_DONE, IDLE).
REQ-027 cfg_wr in IDLE: baud_select <= cfg_baud next edge; if a grant happens the same cycle, the transfer uses the new value (Tx_WR follows update).
REQ-028 cfg_wr outside IDLE: baud_select unchanged, cfg_rej pulses one cycle.
REQ-029 en dropped mid-transfer: current transfer completes normally; TX_EN follows en one cycle later; no new grant while en=0.
REQ-030 Requester deasserting valid before ready: no grant issued to it; no data latched.
REQ-031 Only one ready asserts per cycle; at most one grant per transfer.

Reset
REQ-032 reset=0 forces asynchronously: state IDLE, pointer A, Tx_DATA=8'h00, Tx_WR=0, TX_EN=0, baud_select=3'b000, grant_id=0, a_ready=b_ready=0, ctrl_busy=0, timeout_err=0, cfg_rej=0, counter=0.
REQ-033 Reset asserted mid-transfer aborts it; no Tx_WR or ready pulse is emitted during or on release of reset.

Verification
REQ-034 Single A: en=1, a_valid=1, a_data=8'h55; Tx_BUSY high 2 cycles after Tx_WR for 10 cycles -> a_ready one pulse, Tx_DATA=8'h55, one Tx_WR pulse, ctrl_busy low after Tx_BUSY falls.
REQ-035 Contention: a_valid=b_valid=1 held, data 8'hA1/8'hB2 -> grant order A,B,A,B; Tx_DATA alternates A1,B2.
REQ-036 Timeout: Tx_BUSY tied 0, one request -> timeout_err pulse exactly BUSY_TIMEOUT cycles after entering WAIT_ACK, return to IDLE.
REQ-037 Config: cfg_wr cfg_baud=3'b111 in IDLE -> baud_select=3'b111; cfg_wr=3'b010 during WAIT_DONE -> cfg_rej pulse, baud_select stays 3'b111.
REQ-038 Reset mid-WAIT_DONE: reset=0 -> all outputs at reset values immediately, no Tx_WR after release until a new valid.
REQ-039 en=0 with a_valid=1 -> no ready, no Tx_WR; en=1 -> grant on next cycle.
